// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] NINE = 4'd9;

  // 10**n at 64 bits; large enough for the 9-digit maximum.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle for bin2bcd_seq: master issues start/bin_in,
// slave (the converter) returns ready/done/bcd_out/ovf.
interface bin2bcd_seq_if
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 7,
  parameter int unsigned DIGITS = 2
);

  logic                        start;
  logic [BIN_W-1:0]            bin_in;
  logic                        ready;
  logic                        done;
  logic [DIGIT_W*DIGITS-1:0]   bcd_out;
  logic                        ovf;

  modport master (
    output start, bin_in,
    input  ready, done, bcd_out, ovf
  );

  modport slave (
    input  start, bin_in,
    output ready, done, bcd_out, ovf
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is >= 5.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  // Pre-shift correction so the following doubling carries into the next digit.
  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Optional macro BIN2BCD_SAT_EN: saturate bcd_out to all nines on overflow.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 7,
  parameter int unsigned DIGITS = 2
)(
  input  logic              clk,
  input  logic              rst_n,
  bin2bcd_seq_if.slave      bus
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0] LIMIT = pow10(DIGITS);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q;
  logic [BCD_W-1:0]   work_q;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   work_nx;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;
  logic               ovf_pend_q;
  logic               ovf_next;
  logic               last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .d (work_q[g*DIGIT_W +: DIGIT_W]),
      .q (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Next working value; the top digit's shifted-out bit is dropped by the shift.
  always_comb begin
    work_nx    = (adj << 1) | BCD_W'(shift_q[BIN_W-1]);
    ovf_next   = 64'(bus.bin_in) >= LIMIT;
    last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on start, shift while converting, publish on the last shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            shift_q    <= bus.bin_in;
            work_q     <= '0;
            cnt_q      <= CNT_W'(BIN_W);
            ovf_pend_q <= ovf_next;
          end
        end
        SHIFT: begin
          work_q  <= work_nx;
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (last_shift) begin
            ovf_q <= ovf_pend_q;
`ifdef BIN2BCD_SAT_EN
            bcd_q <= ovf_pend_q ? {DIGITS{NINE}} : work_nx;
`else
            bcd_q <= work_nx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three configurations (7/2, 17/5, 1/1).
module tb_bin2bcd_seq;

`ifdef BIN2BCD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [35:0]  bcd;
    logic         ovf;
    int unsigned  cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int unsigned n_vec;
  int unsigned n_err;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  bin2bcd_seq_if #(.BIN_W(7),  .DIGITS(2)) ia ();
  bin2bcd_seq_if #(.BIN_W(17), .DIGITS(5)) ib ();
  bin2bcd_seq_if #(.BIN_W(1),  .DIGITS(1)) ic ();

  bin2bcd_seq #(.BIN_W(7),  .DIGITS(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  bin2bcd_seq #(.BIN_W(17), .DIGITS(5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  bin2bcd_seq #(.BIN_W(1),  .DIGITS(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitors: pop one expectation per done pulse; latency counted from the
  // cycle in which start was driven (capture edge + BIN_W shift edges).
  always @(negedge clk) begin
    if (rst_n && ia.done) begin
      if (qa.size() == 0) chk("a_unexpected_done", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_bcd", 64'(ia.bcd_out), 64'(e.bcd));
        chk("a_ovf", 64'(ia.ovf), 64'(e.ovf));
        chk("a_latency", 64'(cyc - e.cyc), 64'd8);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ib.done) begin
      if (qb.size() == 0) chk("b_unexpected_done", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_bcd", 64'(ib.bcd_out), 64'(e.bcd));
        chk("b_ovf", 64'(ib.ovf), 64'(e.ovf));
        chk("b_latency", 64'(cyc - e.cyc), 64'd18);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ic.done) begin
      if (qc.size() == 0) chk("c_unexpected_done", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = qc.pop_front();
        chk("c_bcd", 64'(ic.bcd_out), 64'(e.bcd));
        chk("c_ovf", 64'(ic.ovf), 64'(e.ovf));
        chk("c_latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input logic [6:0] v, input logic [7:0] eb, input logic eo, input bit push);
    int unsigned t = 0;
    while (!ia.ready && t < 100) begin step(1); t++; end
    chk("a_ready_wait", 64'(ia.ready), 64'd1);
    ia.bin_in = v;
    ia.start  = 1'b1;
    if (push) qa.push_back('{36'(eb), eo, cyc});
    step(1);
    ia.start  = 1'b0;
    ia.bin_in = ~v;
  endtask

  task automatic issue_b(input logic [16:0] v, input logic [19:0] eb, input logic eo);
    int unsigned t = 0;
    while (!ib.ready && t < 100) begin step(1); t++; end
    chk("b_ready_wait", 64'(ib.ready), 64'd1);
    ib.bin_in = v;
    ib.start  = 1'b1;
    qb.push_back('{36'(eb), eo, cyc});
    step(1);
    ib.start  = 1'b0;
    ib.bin_in = ~v;
  endtask

  task automatic issue_c(input logic v, input logic [3:0] eb, input logic eo);
    int unsigned t = 0;
    while (!ic.ready && t < 100) begin step(1); t++; end
    chk("c_ready_wait", 64'(ic.ready), 64'd1);
    ic.bin_in = v;
    ic.start  = 1'b1;
    qc.push_back('{36'(eb), eo, cyc});
    step(1);
    ic.start  = 1'b0;
    ic.bin_in = ~v;
  endtask

  task automatic drain();
    int unsigned t = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && t < 300) begin step(1); t++; end
    step(2);
    chk("drain_pending", 64'(qa.size() + qb.size() + qc.size()), 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    ia.start = 1'b0; ia.bin_in = '0;
    ib.start = 1'b0; ib.bin_in = '0;
    ic.start = 1'b0; ic.bin_in = '0;

    step(2);
    chk("rst_a_ready", 64'(ia.ready),   64'd1);
    chk("rst_a_done",  64'(ia.done),    64'd0);
    chk("rst_a_bcd",   64'(ia.bcd_out), 64'd0);
    chk("rst_a_ovf",   64'(ia.ovf),     64'd0);
    chk("rst_b_bcd",   64'(ib.bcd_out), 64'd0);
    rst_n = 1'b1;
    step(1);

    // Default configuration.
    issue_a(7'd59,  8'h59, 1'b0, 1'b1); drain();
    issue_a(7'd0,   8'h00, 1'b0, 1'b1); drain();
    issue_a(7'd127, SAT ? 8'h99 : 8'h27, 1'b1, 1'b1); drain();
    issue_a(7'd100, SAT ? 8'h99 : 8'h00, 1'b1, 1'b1); drain();
    issue_a(7'd10,  8'h10, 1'b0, 1'b1); drain();
    issue_a(7'd99,  8'h99, 1'b0, 1'b1); drain();
    step(5);
    chk("a_hold_bcd", 64'(ia.bcd_out), 64'h99);
    chk("a_hold_ovf", 64'(ia.ovf),     64'd0);

    // Wide configuration.
    issue_b(17'd86399,  20'h86399, 1'b0); drain();
    issue_b(17'd100000, SAT ? 20'h99999 : 20'h00000, 1'b1); drain();
    issue_b(17'd99999,  20'h99999, 1'b0); drain();
    issue_b(17'd131071, SAT ? 20'h99999 : 20'h31071, 1'b1); drain();

    // Single-bit configuration.
    issue_c(1'b1, 4'h1, 1'b0); drain();
    issue_c(1'b0, 4'h0, 1'b0); drain();

    // start held high: back-to-back conversions 9 cycles apart, bin_in
    // changed mid-conversion only affects the next capture.
    begin
      int unsigned s;
      s = cyc;
      ia.bin_in = 7'd11;
      ia.start  = 1'b1;
      qa.push_back('{36'h11, 1'b0, s});
      qa.push_back('{36'h99, 1'b0, s + 9});
      qa.push_back('{36'h64, 1'b0, s + 18});
      step(3);
      ia.bin_in = 7'd99;
      step(9);
      ia.bin_in = 7'd64;
      step(8);
      ia.start  = 1'b0;
      ia.bin_in = 7'd5;
      drain();
    end

    // Reset three cycles into a conversion: aborted, nothing published.
    issue_a(7'd45, 8'h45, 1'b0, 1'b0);
    step(2);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_ready", 64'(ia.ready),   64'd1);
    chk("mid_rst_done",  64'(ia.done),    64'd0);
    chk("mid_rst_bcd",   64'(ia.bcd_out), 64'd0);
    step(3);
    rst_n = 1'b1;
    chk("post_rst_ready", 64'(ia.ready),  64'd1);
    step(12);
    chk("post_rst_bcd",  64'(ia.bcd_out), 64'd0);
    issue_a(7'd45, 8'h45, 1'b0, 1'b1); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter BIN_W, default 7: binary input width, legal range 1..32.
REQ-002 The block SHALL have parameter DIGITS, default 2: number of BCD output digits, legal range 1..9.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a conversion of bin_in.
REQ-006 The block SHALL have port bin_in, input, BIN_W bits: unsigned value to convert.
REQ-007 The block SHALL have port ready, output, 1 bit: high when idle and able to accept start.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when bcd_out and ovf are updated.
REQ-009 The block SHALL have port bcd_out, output, 4*DIGITS bits: result; digit 0 (units) in bits [3:0].
REQ-010 The block SHALL have port ovf, output, 1 bit: captured value was >= 10**DIGITS.

Function
REQ-011 The block SHALL use FSM states IDLE, SHIFT and DONE: IDLE->SHIFT on start; SHIFT->DONE after BIN_W shifts; DONE->IDLE unconditionally.
REQ-012 The block SHALL assert ready combinationally only in IDLE, and SHALL sample start only in IDLE; start in SHIFT or DONE is ignored and not queued.
REQ-013 On the start edge, the block SHALL capture bin_in into a shift register, clear the BCD working register, load the bit counter with BIN_W, and capture ovf_next = (bin_in >= 10**DIGITS), compared at a width sufficient for 10**DIGITS.
REQ-014 On each SHIFT edge, the block SHALL add 3 to every working digit that is >= 5, then shift {bcd_work, bin_shift} left by one, MSB of the binary first, and decrement the counter.
REQ-015 The working register SHALL be DIGITS digits wide; bits shifted out of the top digit are discarded.
REQ-016 On the edge that performs the final shift, the block SHALL register bcd_out and ovf and enter DONE; done SHALL be high for exactly the DONE cycle.
REQ-017 Latency SHALL be BIN_W+1 edges from the start edge to done high, for all BIN_W.
REQ-018 bcd_out and ovf SHALL hold their values from the last done pulse until the next done pulse; bin_in changes after capture SHALL have no effect.
REQ-019 Every bcd_out digit SHALL be in the range 0..9 at all times.

Reset
REQ-020 While rst_n is low, the block SHALL force state to IDLE, done to 0, ovf to 0, bcd_out to 0, and the working, shift and counter registers to 0, regardless of clk.
REQ-021 When reset is asserted mid-conversion, the block SHALL abort the conversion with no done pulse; ready SHALL be 1 from reset deassertion.

Configuration
REQ-022 The feature SHALL be controlled by macro BIN2BCD_SAT_EN, which selects overflow saturation.
REQ-023 With BIN2BCD_SAT_EN defined, when ovf_next is 1 the block SHALL load every bcd_out digit with 9 at done.
REQ-024 Without BIN2BCD_SAT_EN, bcd_out SHALL be the low DIGITS decimal digits, i.e. value mod 10**DIGITS.
REQ-025 ovf SHALL be reported identically in both builds.

Structure
REQ-026 The shared package bin2bcd_pkg SHALL contain the FSM state typedef, the BCD digit width constant (4), and the nine-digit constant used for saturation.
REQ-027 The block SHALL instantiate the sub-module bcd_add3 (combinational per-digit "add 3 if >= 5" cell) DIGITS times, once per digit.
REQ-028 The counter width SHALL be $clog2(BIN_W+1).

Verification
REQ-029 Scenario, defaults: bin_in=59, start pulse -> done 8 cycles later, bcd_out=0x59, ovf=0; bin_in=0 -> bcd_out=0x00.
REQ-030 Scenario, defaults: bin_in=127 -> ovf=1; bcd_out=0x99 with BIN2BCD_SAT_EN defined, 0x27 without.
REQ-031 Scenario, BIN_W=17, DIGITS=5: bin_in=86399 -> done 18 cycles after start, bcd_out=0x86399, ovf=0; bin_in=100000 -> ovf=1.
REQ-032 Scenario, defaults: start held high continuously -> conversions every 9 cycles with no overlap; a bin_in change during SHIFT does not alter the result.
REQ-033 Scenario, defaults: rst_n pulsed low 3 cycles into a conversion of 45 -> no done pulse, bcd_out=0x00, ready=1; a new start with 45 then yields 0x45.
REQ-034 Scenario, BIN_W=1, DIGITS=1: bin_in=1 -> done 2 cycles after start, bcd_out=0x1.
